sbh_parity_adjust: RTL and testbench
====================================

Name: sbh_parity_adjust

Overview:
- Sign-bit-hiding decision and correction stage for one 4x4 coefficient group (CG). It sits directly downstream of the absolute-sum stage.
- Captures the CG's quantized coefficients and per-coefficient ±1 rate-distortion costs, then consumes the absolute-sum stage's parity together with the CG's firstNZ/lastNZ.
- Decides whether the sign of the first non-zero coefficient is hidden. On a parity mismatch it applies the cheapest legal ±1 magnitude change, then streams the corrected CG to the entropy-coding side.

Parameters:
- COEFF_W, 16, signed coefficient width
- CG_SIZE, 16, coefficients per CG (index width 4)
- COST_W, 16, unsigned cost width
- SBH_THRESH, 4, minimum (lastNZ - firstNZ) for sign hiding

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  coefficient/cost write strobe
- coef_in  in  COEFF_W  signed quantized coefficient
- index_in  in  4  scan index of coef_in
- cost_up_in  in  COST_W  cost of magnitude +1 at index_in
- cost_dn_in  in  COST_W  cost of magnitude -1 at index_in
- load_done  in  1  qualifies the final write of the CG
- in_ready  out  1  high in LOAD state only
- sum_valid  in  1  absolute-sum result strobe
- parity  in  1  LSB of the absolute sum
- firstNZ  in  4  index of the first non-zero coefficient, sampled with sum_valid
- lastNZ  in  4  index of the last non-zero coefficient, sampled with sum_valid
- out_valid  out  1  corrected-coefficient stream valid
- out_ready  in  1  downstream accept
- out_coef  out  COEFF_W  corrected coefficient
- out_index  out  4  scan index 0..15
- out_last  out  1  high with index 15
- sign_hidden  out  1  CG sign hidden; stable from APPLY until the next LOAD
- adjusted  out  1  a ±1 change was applied; stable as sign_hidden

Behaviour:
- Reset (asynchronous, rst_n low) values:
  - State LOAD, in_ready=1.
  - out_valid=0, out_coef=0, out_index=0, out_last=0, sign_hidden=0, adjusted=0.
  - Coefficient and cost register files cleared.
- States: LOAD -> WAIT_SUM -> SEARCH -> APPLY -> OUTPUT -> LOAD.
- LOAD:
  - Each cycle with valid_in, write coef/cost_up/cost_dn at index_in.
  - valid_in together with load_done writes and moves to WAIT_SUM.
  - valid_in is ignored in every other state.
- WAIT_SUM:
  - On sum_valid, register parity, firstNZ and lastNZ. sum_valid is ignored outside WAIT_SUM.
  - If firstNZ > lastNZ, or (lastNZ - firstNZ) < SBH_THRESH: sign_hidden=0, adjusted=0, go straight to OUTPUT.
  - Otherwise hide_sign = sign bit of coef[firstNZ]. If parity == hide_sign: sign_hidden=1, adjusted=0, go to OUTPUT. Else go to SEARCH with scan=firstNZ and best_cost=all-ones.
- SEARCH: one index per cycle, firstNZ..lastNZ inclusive, so it takes (lastNZ - firstNZ + 1) cycles.
  - Zero coefficients are never candidates.
  - Up candidate is legal if |c| < 2^(COEFF_W-1)-1.
  - Down candidate is legal if |c| >= 2, or if |c| == 1 and the index is neither firstNZ nor lastNZ.
  - A candidate replaces best only if its cost is strictly less than best_cost. Result: lowest index wins on ties, and up is checked before down at the same index.
  - The search records best index, direction and a found flag.
- APPLY (1 cycle):
  - If found: magnitude ±1 with the original sign preserved; sign_hidden=1, adjusted=1.
  - If not found: coefficients unchanged, sign_hidden=0, adjusted=0.
- OUTPUT:
  - Streams indices 0..15 in order with out_valid=1. Advance only on out_valid && out_ready.
  - out_coef, out_index and out_last hold while stalled.
  - After index 15 is accepted: out_valid=0, next cycle is LOAD.
- Latency: from sum_valid to the first out_valid is 1 cycle (no search), or SEARCH length + 2 cycles.
- Arithmetic: magnitudes are unsigned COEFF_W bits; cost comparison is unsigned.
- Reset mid-operation: abandons the CG and returns to the reset values on the next edge.

Decomposition:
- Shared package sbh_pkg:
  - COEFF_W, CG_SIZE, COST_W, SBH_THRESH.
  - State enum sbh_adj_state_t {LOAD, WAIT_SUM, SEARCH, APPLY, OUTPUT}.
  - struct sbh_cand_t {idx, dir_up, cost, found}.
- One natural sub-module, sbh_cand_eval: combinational legality check and cost pick for a single index. It is reused by SEARCH.

Test Plan:
1. Coefs idx2=-3, idx3=1, idx5=2, idx9=1, others 0; firstNZ=2, lastNZ=9, parity=1 -> sign_hidden=1, adjusted=0, output equals input, first out_valid 1 cycle after sum_valid.
2. Same CG with idx2=+3, parity=1; cost_dn[5]=4, all other costs 50 -> SEARCH 8 cycles, out_coef@5=1, adjusted=1, sign_hidden=1.
3. Tie case: as test 2 plus cost_dn[3]=4 -> idx3 chosen (lowest index), out_coef@3=0, out_coef@5=2.
4. firstNZ=2, lastNZ=5 (span 3 < 4) -> sign_hidden=0, adjusted=0, coefficients unchanged; empty CG (firstNZ=15, lastNZ=0) -> same result.
5. out_ready held low 3 cycles at index 7 -> out_index=7 and out_coef stable, 16 accepts total, out_last only at index 15.
6. rst_n asserted during SEARCH -> all outputs 0 and in_ready=1 immediately; next CG processes correctly.

Source files
------------

// File: rtl/sbh_parity_adjust_pkg.sv
// ------------------------------------------------------------------------------
// sbh_pkg: shared constants, state and candidate types for sbh_parity_adjust. Rev 1.0
// ------------------------------------------------------------------------------
`default_nettype none

package sbh_pkg;

  localparam int COEFF_W    = 16;
  localparam int CG_SIZE    = 16;
  localparam int COST_W     = 16;
  localparam int SBH_THRESH = 4;
  localparam int IDX_W      = 4;

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    WAIT_SUM = 3'd1,
    SEARCH   = 3'd2,
    APPLY    = 3'd3,
    OUTPUT   = 3'd4
  } sbh_adj_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              dir_up;
    logic [COST_W-1:0] cost;
    logic              found;
  } sbh_cand_t;

  // Magnitude of a two's-complement coefficient, kept as an unsigned COEFF_W value.
  function automatic logic [COEFF_W-1:0] sbh_abs(input logic [COEFF_W-1:0] c);
    return c[COEFF_W-1] ? (~c + COEFF_W'(1)) : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sbh_parity_adjust_if.sv
// ------------------------------------------------------------------------------
// sbh_parity_adjust_if: load, absolute-sum and output-stream signals of the SBH stage. Rev 1.0
// ------------------------------------------------------------------------------
`default_nettype none

interface sbh_parity_adjust_if;

  logic                            valid_in;
  logic [sbh_pkg::COEFF_W-1:0]     coef_in;
  logic [sbh_pkg::IDX_W-1:0]       index_in;
  logic [sbh_pkg::COST_W-1:0]      cost_up_in;
  logic [sbh_pkg::COST_W-1:0]      cost_dn_in;
  logic                            load_done;
  logic                            in_ready;
  logic                            sum_valid;
  logic                            parity;
  logic [sbh_pkg::IDX_W-1:0]       firstNZ;
  logic [sbh_pkg::IDX_W-1:0]       lastNZ;
  logic                            out_valid;
  logic                            out_ready;
  logic [sbh_pkg::COEFF_W-1:0]     out_coef;
  logic [sbh_pkg::IDX_W-1:0]       out_index;
  logic                            out_last;
  logic                            sign_hidden;
  logic                            adjusted;

  modport master (
    output valid_in, coef_in, index_in, cost_up_in, cost_dn_in, load_done,
    output sum_valid, parity, firstNZ, lastNZ, out_ready,
    input  in_ready, out_valid, out_coef, out_index, out_last, sign_hidden, adjusted
  );

  modport slave (
    input  valid_in, coef_in, index_in, cost_up_in, cost_dn_in, load_done,
    input  sum_valid, parity, firstNZ, lastNZ, out_ready,
    output in_ready, out_valid, out_coef, out_index, out_last, sign_hidden, adjusted
  );

endinterface

`default_nettype wire

// File: rtl/sbh_parity_adjust_cand_eval.sv
// ------------------------------------------------------------------------------
// sbh_cand_eval: legality check and cost pick of the +1/-1 candidates at one index. Rev 1.0
// ------------------------------------------------------------------------------
`default_nettype none

module sbh_cand_eval
  import sbh_pkg::*;
(
  input  logic [COEFF_W-1:0] coef,
  input  logic [IDX_W-1:0]   idx,
  input  logic [IDX_W-1:0]   first_nz,
  input  logic [IDX_W-1:0]   last_nz,
  input  logic [COST_W-1:0]  cost_up,
  input  logic [COST_W-1:0]  cost_dn,
  input  sbh_cand_t          best_in,
  output sbh_cand_t          best_out
);

  localparam logic [COEFF_W-1:0] C_MAG_MAX = {1'b0, {(COEFF_W-1){1'b1}}};
  localparam logic [COEFF_W-1:0] C_ONE     = COEFF_W'(1);
  localparam logic [COEFF_W-1:0] C_TWO     = COEFF_W'(2);

  logic [COEFF_W-1:0] w_mag;
  logic               w_nz;
  logic               w_up_ok;
  logic               w_dn_ok;
  sbh_cand_t          w_after_up;

  assign w_mag   = sbh_abs(coef);
  assign w_nz    = |coef;
  assign w_up_ok = w_nz && (w_mag < C_MAG_MAX);
  // A magnitude-1 endpoint may not drop to zero: that would move firstNZ/lastNZ.
  assign w_dn_ok = w_nz && ((w_mag >= C_TWO) ||
                            ((w_mag == C_ONE) && (idx != first_nz) && (idx != last_nz)));

  always_comb begin
    w_after_up = best_in;
    if (w_up_ok && (cost_up < best_in.cost)) begin
      w_after_up = '{idx: idx, dir_up: 1'b1, cost: cost_up, found: 1'b1};
    end
    best_out = w_after_up;
    if (w_dn_ok && (cost_dn < w_after_up.cost)) begin
      best_out = '{idx: idx, dir_up: 1'b0, cost: cost_dn, found: 1'b1};
    end
  end

endmodule

`default_nettype wire

// File: rtl/sbh_parity_adjust.sv
// ------------------------------------------------------------------------------
// sbh_parity_adjust: sign-bit-hiding decision and cheapest +/-1 parity fix for one 4x4 CG. Rev 1.0
// ------------------------------------------------------------------------------
`default_nettype none

module sbh_parity_adjust
  import sbh_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  sbh_parity_adjust_if.slave bus
);

  localparam logic [2:0]         S_LOAD     = LOAD;
  localparam logic [2:0]         S_WAIT_SUM = WAIT_SUM;
  localparam logic [2:0]         S_SEARCH   = SEARCH;
  localparam logic [2:0]         S_APPLY    = APPLY;
  localparam logic [2:0]         S_OUTPUT   = OUTPUT;
  localparam logic [IDX_W-1:0]   C_LAST_IDX = IDX_W'(CG_SIZE-1);
  localparam logic [IDX_W-1:0]   C_IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]   C_THRESH   = IDX_W'(SBH_THRESH);
  localparam logic [COEFF_W-1:0] C_ONE      = COEFF_W'(1);

  logic [2:0]         r_state;
  logic [COEFF_W-1:0] r_coef [CG_SIZE];
  logic [COST_W-1:0]  r_cost_up [CG_SIZE];
  logic [COST_W-1:0]  r_cost_dn [CG_SIZE];
  logic [IDX_W-1:0]   r_first;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_scan;
  sbh_cand_t          r_best;
  logic               r_out_valid;
  logic [COEFF_W-1:0] r_out_coef;
  logic [IDX_W-1:0]   r_out_idx;
  logic               r_out_last;
  logic               r_sign_hidden;
  logic               r_adjusted;

  logic [IDX_W-1:0]   w_span;
  logic               w_skip;
  logic [COEFF_W-1:0] w_first_sel;
  logic               w_hide;
  sbh_cand_t          w_cand;
  logic [COEFF_W-1:0] w_tgt;
  logic [COEFF_W-1:0] w_tgt_mag;
  logic [COEFF_W-1:0] w_new_mag;
  logic [COEFF_W-1:0] w_new_coef;
  logic [COEFF_W-1:0] w_out0_coef;
  logic [IDX_W-1:0]   w_next_idx;

  assign w_span      = bus.lastNZ - bus.firstNZ;
  assign w_skip      = (bus.firstNZ > bus.lastNZ) || (w_span < C_THRESH);
  assign w_first_sel = r_coef[bus.firstNZ];
  assign w_hide      = w_first_sel[COEFF_W-1];

  sbh_cand_eval u_cand_eval (
    .coef     (r_coef[r_scan]),
    .idx      (r_scan),
    .first_nz (r_first),
    .last_nz  (r_last),
    .cost_up  (r_cost_up[r_scan]),
    .cost_dn  (r_cost_dn[r_scan]),
    .best_in  (r_best),
    .best_out (w_cand)
  );

  // Magnitude moves by one while the original sign is kept.
  assign w_tgt       = r_coef[r_best.idx];
  assign w_tgt_mag   = sbh_abs(w_tgt);
  assign w_new_mag   = r_best.dir_up ? (w_tgt_mag + C_ONE) : (w_tgt_mag - C_ONE);
  assign w_new_coef  = w_tgt[COEFF_W-1] ? (~w_new_mag + C_ONE) : w_new_mag;
  assign w_out0_coef = (r_best.found && (r_best.idx == '0)) ? w_new_coef : r_coef[0];
  assign w_next_idx  = r_out_idx + C_IDX_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_LOAD;
      r_first       <= '0;
      r_last        <= '0;
      r_scan        <= '0;
      r_best        <= '0;
      r_out_valid   <= 1'b0;
      r_out_coef    <= '0;
      r_out_idx     <= '0;
      r_out_last    <= 1'b0;
      r_sign_hidden <= 1'b0;
      r_adjusted    <= 1'b0;
      for (int i = 0; i < CG_SIZE; i++) begin
        r_coef[i]    <= '0;
        r_cost_up[i] <= '0;
        r_cost_dn[i] <= '0;
      end
    end else begin
      case (r_state)
        S_LOAD: begin
          if (bus.valid_in) begin
            r_coef[bus.index_in]    <= bus.coef_in;
            r_cost_up[bus.index_in] <= bus.cost_up_in;
            r_cost_dn[bus.index_in] <= bus.cost_dn_in;
            if (bus.load_done) r_state <= S_WAIT_SUM;
          end
        end
        S_WAIT_SUM: begin
          if (bus.sum_valid) begin
            r_first <= bus.firstNZ;
            r_last  <= bus.lastNZ;
            r_scan  <= bus.firstNZ;
            r_best  <= '{idx: '0, dir_up: 1'b0, cost: '1, found: 1'b0};
            if (w_skip || (bus.parity == w_hide)) begin
              r_sign_hidden <= !w_skip;
              r_adjusted    <= 1'b0;
              r_out_valid   <= 1'b1;
              r_out_idx     <= '0;
              r_out_last    <= 1'b0;
              r_out_coef    <= r_coef[0];
              r_state       <= S_OUTPUT;
            end else begin
              r_state <= S_SEARCH;
            end
          end
        end
        S_SEARCH: begin
          r_best <= w_cand;
          if (r_scan == r_last) r_state <= S_APPLY;
          else                  r_scan  <= r_scan + C_IDX_ONE;
        end
        S_APPLY: begin
          if (r_best.found) r_coef[r_best.idx] <= w_new_coef;
          r_sign_hidden <= r_best.found;
          r_adjusted    <= r_best.found;
          r_out_valid   <= 1'b1;
          r_out_idx     <= '0;
          r_out_last    <= 1'b0;
          r_out_coef    <= w_out0_coef;
          r_state       <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (r_out_valid && bus.out_ready) begin
            if (r_out_idx == C_LAST_IDX) begin
              r_out_valid   <= 1'b0;
              r_out_idx     <= '0;
              r_out_last    <= 1'b0;
              r_out_coef    <= '0;
              r_sign_hidden <= 1'b0;
              r_adjusted    <= 1'b0;
              r_state       <= S_LOAD;
            end else begin
              r_out_idx  <= w_next_idx;
              r_out_coef <= r_coef[w_next_idx];
              r_out_last <= (w_next_idx == C_LAST_IDX);
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == S_LOAD);
  assign bus.out_valid   = r_out_valid;
  assign bus.out_coef    = r_out_coef;
  assign bus.out_index   = r_out_idx;
  assign bus.out_last    = r_out_last;
  assign bus.sign_hidden = r_sign_hidden;
  assign bus.adjusted    = r_adjusted;

endmodule

`default_nettype wire

// File: tb/tb_sbh_parity_adjust.sv
// ------------------------------------------------------------------------------
// tb_sbh_parity_adjust: directed and random CGs checked against a behavioural SBH model. Rev 1.0
// ------------------------------------------------------------------------------
`default_nettype none

module tb_sbh_parity_adjust;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sbh_parity_adjust_if bus ();

  sbh_parity_adjust dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic signed [15:0] cg_c [16];
  logic [15:0]        cg_u [16];
  logic [15:0]        cg_d [16];
  logic [15:0]        exp_c [16];
  logic               exp_h;
  logic               exp_a;
  int                 exp_lat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: pick the minimum over keys cost*64 + idx*2 + (down ? 1 : 0).
  task automatic model(input logic p, input logic [3:0] f, input logic [3:0] l);
    int fi, li, v, m, key, best_key, bi;
    bit bup;
    fi = f; li = l;
    for (int i = 0; i < 16; i++) exp_c[i] = cg_c[i];
    exp_h = 1'b0; exp_a = 1'b0; exp_lat = 1;
    if (fi > li || (li - fi) < 4) return;
    if (p == cg_c[fi][15]) begin exp_h = 1'b1; return; end
    exp_lat = li - fi + 3;
    best_key = -1;
    for (int i = fi; i <= li; i++) begin
      v = cg_c[i];
      m = (v < 0) ? -v : v;
      if (m == 0) continue;
      if (m < 32767 && cg_u[i] != 16'hffff) begin
        key = int'(cg_u[i]) * 64 + i * 2;
        if (best_key < 0 || key < best_key) best_key = key;
      end
      if ((m >= 2 || (m == 1 && i != fi && i != li)) && cg_d[i] != 16'hffff) begin
        key = int'(cg_d[i]) * 64 + i * 2 + 1;
        if (best_key < 0 || key < best_key) best_key = key;
      end
    end
    if (best_key >= 0) begin
      bi  = (best_key % 64) / 2;
      bup = (best_key % 2) == 0;
      v   = cg_c[bi];
      m   = (v < 0) ? -v : v;
      m   = bup ? m + 1 : m - 1;
      exp_c[bi] = 16'((v < 0) ? -m : m);
      exp_h = 1'b1; exp_a = 1'b1;
    end
  endtask

  task automatic load_cg();
    chk("in_ready_load", bus.in_ready, 1);
    for (int i = 0; i < 16; i++) begin
      bus.valid_in = 1'b1; bus.index_in = 4'(i); bus.coef_in = cg_c[i];
      bus.cost_up_in = cg_u[i]; bus.cost_dn_in = cg_d[i]; bus.load_done = (i == 15);
      tick();
    end
    bus.valid_in = 1'b0; bus.load_done = 1'b0;
    chk("in_ready_after_load", bus.in_ready, 0);
  endtask

  task automatic do_sum(input logic p, input logic [3:0] f, input logic [3:0] l);
    int cyc;
    model(p, f, l);
    bus.sum_valid = 1'b1; bus.parity = p; bus.firstNZ = f; bus.lastNZ = l;
    tick();
    cyc = 1;
    bus.sum_valid = 1'b0;
    while (!bus.out_valid && cyc < 200) begin tick(); cyc++; end
    chk("latency", cyc, exp_lat);
  endtask

  task automatic collect(input int stall_idx);
    for (int k = 0; k < 16; k++) begin
      if (k == stall_idx) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("stall_index", bus.out_index, k);
          chk("stall_coef", bus.out_coef, exp_c[k]);
          chk("stall_valid", bus.out_valid, 1);
        end
      end
      chk("out_valid", bus.out_valid, 1);
      chk("out_index", bus.out_index, k);
      chk("out_coef", bus.out_coef, exp_c[k]);
      chk("out_last", bus.out_last, (k == 15));
      chk("sign_hidden", bus.sign_hidden, exp_h);
      chk("adjusted", bus.adjusted, exp_a);
      bus.out_ready = 1'b1;
      tick();
    end
    chk("done_valid", bus.out_valid, 0);
    chk("done_in_ready", bus.in_ready, 1);
  endtask

  task automatic set_base_cg(input logic signed [15:0] c2);
    for (int i = 0; i < 16; i++) begin cg_c[i] = 16'sd0; cg_u[i] = 16'd50; cg_d[i] = 16'd50; end
    cg_c[2] = c2; cg_c[3] = 16'sd1; cg_c[5] = 16'sd2; cg_c[9] = 16'sd1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_coef"}, bus.out_coef, 0);
    chk({tag, "_out_index"}, bus.out_index, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_sign_hidden"}, bus.sign_hidden, 0);
    chk({tag, "_adjusted"}, bus.adjusted, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
  endtask

  task automatic random_cg();
    int r, f, l;
    f = 15; l = 0;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      cg_c[i] = 16'sd0;
      else if (r < 9) cg_c[i] = 16'($signed($urandom_range(0, 6)) - 3);
      else            cg_c[i] = ($urandom_range(0, 1) == 1) ? 16'sh7fff : 16'sh8000;
      cg_u[i] = ($urandom_range(0, 15) == 0) ? 16'hffff : 16'($urandom_range(0, 40));
      cg_d[i] = ($urandom_range(0, 15) == 0) ? 16'hffff : 16'($urandom_range(0, 40));
    end
    for (int i = 15; i >= 0; i--) if (cg_c[i] != 0) f = i;
    for (int i = 0; i < 16; i++)  if (cg_c[i] != 0) l = i;
    load_cg();
    do_sum(1'($urandom_range(0, 1)), 4'(f), 4'(l));
    collect(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1);
  endtask

  initial begin
    bus.valid_in = 1'b0; bus.coef_in = '0; bus.index_in = '0; bus.cost_up_in = '0;
    bus.cost_dn_in = '0; bus.load_done = 1'b0; bus.sum_valid = 1'b0; bus.parity = 1'b0;
    bus.firstNZ = '0; bus.lastNZ = '0; bus.out_ready = 1'b1;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Parity already matches the sign of coef[firstNZ].
    set_base_cg(-16'sd3);
    load_cg(); do_sum(1'b1, 4'd2, 4'd9); collect(-1);

    // Mismatch, cheapest fix is down at index 5.
    set_base_cg(16'sd3); cg_d[5] = 16'd4;
    load_cg(); do_sum(1'b1, 4'd2, 4'd9);
    chk("t2_coef5_expect", exp_c[5], 16'd1);
    collect(-1);

    // Equal-cost tie: lower index 3 wins.
    set_base_cg(16'sd3); cg_d[5] = 16'd4; cg_d[3] = 16'd4;
    load_cg(); do_sum(1'b1, 4'd2, 4'd9); collect(-1);

    // Span below threshold, then an empty CG.
    set_base_cg(16'sd3);
    load_cg(); do_sum(1'b1, 4'd2, 4'd5); collect(-1);
    for (int i = 0; i < 16; i++) cg_c[i] = 16'sd0;
    load_cg(); do_sum(1'b1, 4'd15, 4'd0); collect(-1);

    // Backpressure at index 7 on an adjusted CG.
    set_base_cg(16'sd3); cg_u[9] = 16'd2;
    load_cg(); do_sum(1'b1, 4'd2, 4'd9); collect(7);

    // Reset in the middle of SEARCH, then a clean rerun.
    set_base_cg(16'sd3); cg_d[5] = 16'd4;
    load_cg();
    bus.sum_valid = 1'b1; bus.parity = 1'b1; bus.firstNZ = 4'd2; bus.lastNZ = 4'd9;
    tick(); bus.sum_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    load_cg(); do_sum(1'b1, 4'd2, 4'd9); collect(-1);

    for (int n = 0; n < 25; n++) random_cg();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
